// File: rtl/hit_event_arbiter.sv
// Latches per-source hit events and delivers at most one per frame to the mover as a
// 1-cycle collision pulse with its edge code; sources are served round-robin.
//   state    | meaning
//   IDLE_ST  | disabled, no grants, pending events kept
//   ARB_ST   | search for first pending source from the rr pointer
//   GRANT_ST | collision pulse carrying the winner's edge code
//   HOLD_ST  | wait for the next startOfFrame
module hit_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int DROP_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   hit_req,
  input  logic [4*NUM_SRC-1:0] hit_edge,
  output logic                 collision,
  output logic [3:0]           HitEdgeCode,
  output logic [ID_W-1:0]      grant_id,
  output logic [NUM_SRC-1:0]   pending,
  output logic [DROP_W-1:0]    dropped_cnt
);

  typedef enum logic [1:0] {IDLE_ST, ARB_ST, GRANT_ST, HOLD_ST} state_t;

  state_t             state, state_nxt;
  logic [3:0]         edge_reg [NUM_SRC];
  logic [ID_W-1:0]    rr_ptr, pick, rr_nxt;
  logic               found, load_win;
  logic [ID_W:0]      idx;
  logic [NUM_SRC-1:0] gnt_vec, merge_vec;
  logic [DROP_W:0]    merge_n, drop_sum;

  // Round-robin search: first pending source at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(j);
      if (idx >= (ID_W+1)'(NUM_SRC)) idx = idx - (ID_W+1)'(NUM_SRC);
      if (!found && pending[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
    rr_nxt = (pick == ID_W'(NUM_SRC-1)) ? '0 : pick + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load_win  = 1'b0;
    case (state)
      IDLE_ST:  if (enable) state_nxt = ARB_ST;
      ARB_ST: begin
        if (!enable) begin
          state_nxt = IDLE_ST;
        end else if (found) begin
          state_nxt = GRANT_ST;
          load_win  = 1'b1;
        end
      end
      GRANT_ST: state_nxt = HOLD_ST;
      HOLD_ST:  if (startOfFrame) state_nxt = enable ? ARB_ST : IDLE_ST;
      default:  state_nxt = IDLE_ST;
    endcase
  end

  // Every merged event counts once, even when several sources merge in one cycle.
  always_comb begin
    gnt_vec   = '0;
    merge_vec = '0;
    merge_n   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt_vec[i]   = (state == GRANT_ST) && (grant_id == ID_W'(i));
      merge_vec[i] = hit_req[i] && pending[i] && !gnt_vec[i];
      merge_n      = merge_n + (DROP_W+1)'(merge_vec[i]);
    end
    drop_sum = {1'b0, dropped_cnt} + merge_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE_ST;
      rr_ptr      <= '0;
      grant_id    <= '0;
      pending     <= '0;
      dropped_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) edge_reg[i] <= 4'b0;
    end else begin
      state       <= state_nxt;
      dropped_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (load_win) begin
        grant_id <= pick;
        rr_ptr   <= rr_nxt;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gnt_vec[i]) begin
          if (hit_req[i]) begin
            edge_reg[i] <= hit_edge[4*i +: 4];
          end else begin
            pending[i]  <= 1'b0;
            edge_reg[i] <= 4'b0;
          end
        end else if (hit_req[i]) begin
          pending[i]  <= 1'b1;
          edge_reg[i] <= pending[i] ? (edge_reg[i] | hit_edge[4*i +: 4]) : hit_edge[4*i +: 4];
        end
      end
    end
  end

  assign collision   = (state == GRANT_ST);
  assign HitEdgeCode = collision ? edge_reg[grant_id] : 4'b0;

endmodule

// File: tb/tb_hit_event_arbiter.sv
// Bench for hit_event_arbiter: directed scenarios with fixed expectations, then a long
// randomized run compared every cycle against a frame-level behavioural model.
module tb_hit_event_arbiter;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, enable;
  logic [3:0]  hit_req;
  logic [15:0] hit_edge;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [1:0]  grant_id;
  logic [3:0]  pending;
  logic [7:0]  dropped_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int P_IDLE = 0, P_ARB = 1, P_GRANT = 2, P_HOLD = 3;
  int         m_phase, m_rr, m_win, m_drop;
  bit         m_pend [4];
  logic [3:0] m_edge [4];

  hit_event_arbiter #(.NUM_SRC(4), .ID_W(2), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .hit_req(hit_req), .hit_edge(hit_edge), .collision(collision),
    .HitEdgeCode(HitEdgeCode), .grant_id(grant_id), .pending(pending),
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one call per clock edge, using the inputs just sampled.
  task automatic model_step();
    bit granting;
    int gw, w, s;
    logic [3:0] e;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_edge[i] = 4'h0; end
      m_drop = 0; m_rr = 0; m_win = 0; m_phase = P_IDLE;
    end else begin
      granting = (m_phase == P_GRANT);
      gw = m_win;
      w = -1;
      for (int j = 0; j < 4; j++) begin
        s = (m_rr + j) % 4;
        if (w < 0 && m_pend[s]) w = s;
      end
      case (m_phase)
        P_IDLE: if (enable) m_phase = P_ARB;
        P_ARB: begin
          if (!enable) m_phase = P_IDLE;
          else if (w >= 0) begin m_phase = P_GRANT; m_win = w; m_rr = (w + 1) % 4; end
        end
        P_GRANT: m_phase = P_HOLD;
        default: if (startOfFrame) m_phase = enable ? P_ARB : P_IDLE;
      endcase
      for (int i = 0; i < 4; i++) begin
        e = hit_edge[4*i +: 4];
        if (granting && i == gw) begin
          if (hit_req[i]) m_edge[i] = e;
          else begin m_pend[i] = 0; m_edge[i] = 4'h0; end
        end else if (hit_req[i]) begin
          if (m_pend[i]) begin
            m_edge[i] = m_edge[i] | e;
            if (m_drop < 255) m_drop++;
          end else begin
            m_pend[i] = 1; m_edge[i] = e;
          end
        end
      end
    end
  endtask

  task automatic step(input int req, input int edg, input int sof, input int en, input int rst);
    hit_req      = req[3:0];
    hit_edge     = edg[15:0];
    startOfFrame = (sof != 0);
    enable       = (en != 0);
    reset        = (rst != 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(4'hF, 16'hFFFF, 1, 1, 1);
    step(4'hF, 16'hFFFF, 1, 1, 1);
    tests_run++; if (collision !== 1'b0) begin tests_failed++; $display("FAIL t1_collision got %b exp 0", collision); end
    tests_run++; if (HitEdgeCode !== 4'h0) begin tests_failed++; $display("FAIL t1_hec got %h exp 0", HitEdgeCode); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL t1_grant_id got %0d exp 0", grant_id); end
    tests_run++; if (pending !== 4'h0) begin tests_failed++; $display("FAIL t1_pending got %b exp 0000", pending); end
    tests_run++; if (dropped_cnt !== 8'd0) begin tests_failed++; $display("FAIL t1_dropped got %0d exp 0", dropped_cnt); end
    step(0, 0, 0, 0, 0);
    tests_run++; if (pending !== 4'h0) begin tests_failed++; $display("FAIL t1_pending_after got %b exp 0000", pending); end
  endtask

  task automatic test_single_hit();
    int ncol;
    step(0, 0, 0, 1, 0);
    step(4'b0100, 16'h0400, 0, 1, 0);
    tests_run++; if (pending !== 4'b0100 || collision !== 1'b0) begin tests_failed++; $display("FAIL t2_latch got pend=%b col=%b exp pend=0100 col=0", pending, collision); end
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1) begin tests_failed++; $display("FAIL t2_collision got %b exp 1", collision); end
    tests_run++; if (HitEdgeCode !== 4'b0100) begin tests_failed++; $display("FAIL t2_hec got %b exp 0100", HitEdgeCode); end
    tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("FAIL t2_grant_id got %0d exp 2", grant_id); end
    step(0, 0, 0, 1, 0);
    tests_run++; if (pending !== 4'h0 || collision !== 1'b0 || HitEdgeCode !== 4'h0 || grant_id !== 2'd2) begin
      tests_failed++; $display("FAIL t2_after got pend=%b col=%b hec=%b id=%0d exp 0000/0/0000/2", pending, collision, HitEdgeCode, grant_id);
    end
    ncol = 0;
    step(4'b0100, 16'h0400, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin step(0, 0, 0, 1, 0); if (collision) ncol++; end
    tests_run++; if (ncol != 0) begin tests_failed++; $display("FAIL t2_no_second_pulse got %0d pulses exp 0", ncol); end
  endtask

  task automatic test_round_robin();
    int exp_id [4];
    logic [3:0] exp_hec [4];
    int ncol;
    logic [1:0] gid;
    logic [3:0] hec;
    exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 3; exp_id[3] = 0;
    exp_hec[0] = 4'h1; exp_hec[1] = 4'h2; exp_hec[2] = 4'h8; exp_hec[3] = 4'h4;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(4'b1011, 16'h8021, 0, 1, 0);
    for (int f = 0; f < 4; f++) begin
      ncol = 0; gid = 2'd0; hec = 4'h0;
      if (f == 3) step(4'b1001, 16'h4004, 0, 1, 0);
      for (int c = 0; c < 6; c++) begin
        step(0, 0, 0, 1, 0);
        if (collision) begin ncol++; gid = grant_id; hec = HitEdgeCode; end
      end
      tests_run++; if (ncol != 1) begin tests_failed++; $display("FAIL t3_pulses_frame%0d got %0d exp 1", f, ncol); end
      tests_run++; if (gid !== 2'(exp_id[f]) || hec !== exp_hec[f]) begin
        tests_failed++; $display("FAIL t3_grant_frame%0d got id=%0d hec=%b exp id=%0d hec=%b", f, gid, hec, exp_id[f], exp_hec[f]);
      end
      step(0, 0, 1, 1, 0);
    end
  endtask

  task automatic test_merge_drop();
    int ncol;
    step(0, 0, 0, 0, 1);
    step(4'b0010, 16'h0010, 0, 0, 0);
    step(4'b0010, 16'h0080, 0, 0, 0);
    tests_run++; if (dropped_cnt !== 8'd1 || pending !== 4'b0010) begin tests_failed++; $display("FAIL t4_merge got drop=%0d pend=%b exp 1/0010", dropped_cnt, pending); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1 || HitEdgeCode !== 4'b1001 || grant_id !== 2'd1) begin
      tests_failed++; $display("FAIL t4_merged_delivery got col=%b hec=%b id=%0d exp 1/1001/1", collision, HitEdgeCode, grant_id);
    end
    step(0, 0, 0, 0, 0);
    ncol = 0;
    for (int k = 0; k < 254; k++) begin step(4'b0010, 16'h0010 << (k % 4), 0, 0, 0); if (collision) ncol++; end
    tests_run++; if (dropped_cnt !== 8'd254) begin tests_failed++; $display("FAIL t4_drop_254 got %0d exp 254", dropped_cnt); end
    for (int k = 0; k < 47; k++) begin step(4'b0010, 16'h0040, 0, 0, 0); if (collision) ncol++; end
    tests_run++; if (dropped_cnt !== 8'd255) begin tests_failed++; $display("FAIL t4_drop_saturate got %0d exp 255", dropped_cnt); end
    tests_run++; if (ncol != 0) begin tests_failed++; $display("FAIL t4_no_grant_disabled got %0d pulses exp 0", ncol); end
  endtask

  task automatic test_grant_cycle_hit();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(4'b0001, 16'h0001, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1 || HitEdgeCode !== 4'b0001 || grant_id !== 2'd0) begin
      tests_failed++; $display("FAIL t5_first_grant got col=%b hec=%b id=%0d exp 1/0001/0", collision, HitEdgeCode, grant_id);
    end
    step(4'b0001, 16'h0002, 1, 1, 0);
    tests_run++; if (pending !== 4'b0001 || collision !== 1'b0 || dropped_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL t5_rehit got pend=%b col=%b drop=%0d exp 0001/0/0", pending, collision, dropped_cnt);
    end
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b0) begin tests_failed++; $display("FAIL t5_sof_in_grant_consumed got col=%b exp 0", collision); end
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1 || HitEdgeCode !== 4'b0010) begin
      tests_failed++; $display("FAIL t5_new_event got col=%b hec=%b exp 1/0010", collision, HitEdgeCode);
    end
  endtask

  task automatic test_enable_reset();
    int ncol;
    step(0, 0, 0, 0, 1);
    step(4'b0110, 16'h0430, 0, 0, 0);
    ncol = 0;
    for (int c = 0; c < 4; c++) begin step(0, 0, 1, 0, 0); if (collision) ncol++; end
    tests_run++; if (ncol != 0 || pending !== 4'b0110) begin tests_failed++; $display("FAIL t6_disabled got pulses=%0d pend=%b exp 0/0110", ncol, pending); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1 || grant_id !== 2'd1 || HitEdgeCode !== 4'b0011) begin
      tests_failed++; $display("FAIL t6_grant1 got col=%b id=%0d hec=%b exp 1/1/0011", collision, grant_id, HitEdgeCode);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ncol = 0;
    for (int c = 0; c < 4; c++) begin step(0, 0, 1, 0, 0); if (collision) ncol++; end
    tests_run++; if (ncol != 0 || pending !== 4'b0100) begin tests_failed++; $display("FAIL t6_idle_after_hold got pulses=%0d pend=%b exp 0/0100", ncol, pending); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    tests_run++; if (collision !== 1'b1 || grant_id !== 2'd2 || HitEdgeCode !== 4'b0100) begin
      tests_failed++; $display("FAIL t6_grant2 got col=%b id=%0d hec=%b exp 1/2/0100", collision, grant_id, HitEdgeCode);
    end
    step(0, 0, 0, 1, 0);
    step(4'b0001, 16'h0008, 0, 1, 0);
    tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL t6_pend_in_hold got %b exp 0001", pending); end
    step(4'hF, 16'hFFFF, 1, 1, 1);
    tests_run++; if (pending !== 4'h0 || collision !== 1'b0) begin tests_failed++; $display("FAIL t6_reset_in_hold got pend=%b col=%b exp 0000/0", pending, collision); end
    ncol = 0;
    for (int c = 0; c < 4; c++) begin step(0, 0, 0, 1, 0); if (collision) ncol++; end
    tests_run++; if (ncol != 0) begin tests_failed++; $display("FAIL t6_no_pulse_after_reset got %0d exp 0", ncol); end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] exp_pend, exp_hec;
    logic exp_col;
    step(0, 0, 0, 1, 1);
    for (int n = 0; n < 3000; n++) begin
      r = 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) r = r | (1 << b);
      step(r, int'($urandom_range(0, 65535)), int'($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 299) == 0));
      for (int i = 0; i < 4; i++) exp_pend[i] = m_pend[i];
      exp_col = (m_phase == P_GRANT);
      exp_hec = exp_col ? m_edge[m_win] : 4'h0;
      tests_run++;
      if ({collision, HitEdgeCode, grant_id, pending, dropped_cnt} !==
          {exp_col, exp_hec, 2'(m_win), exp_pend, 8'(m_drop)}) begin
        tests_failed++;
        $display("FAIL rand_cycle%0d got col=%b hec=%b id=%0d pend=%b drop=%0d exp col=%b hec=%b id=%0d pend=%b drop=%0d",
                 n, collision, HitEdgeCode, grant_id, pending, dropped_cnt,
                 exp_col, exp_hec, m_win, exp_pend, m_drop);
      end
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b0; hit_req = 4'h0; hit_edge = 16'h0;
    @(negedge clk);
    test_reset();
    test_single_hit();
    test_round_robin();
    test_merge_drop();
    test_grant_cycle_hit();
    test_enable_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
